// File: rtl/mem_access.sv
// Load/store unit for the memory stage: aligns store data into byte lanes, waits for
// the memory handshake, and extracts and extends load data into the writeback result.
module mem_access_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  size,
  input  logic [1:0]  lo,
  input  logic        is_st,
  input  logic [31:0] wdata,
  output logic        we,
  output logic [7:0]  wbyte
);
  localparam logic [1:0] LID = 2'(LANE);

  always_comb begin
    we    = 1'b0;
    wbyte = wdata[7:0];
    if (size[1]) begin
      we    = is_st;
      wbyte = wdata[8*LANE +: 8];
    end else if (size[0]) begin
      we    = is_st & (lo[1] == LID[1]);
      wbyte = wdata[8*(LANE%2) +: 8];
    end else begin
      we    = is_st & (lo == LID);
    end
  end
endmodule

module mem_access #(
  parameter int ADDR_W = 30
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enabled,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       wdata,
  output logic              mem_req,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              completed,
  output logic [31:0]       result,
  output logic              misaligned
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_nxt;

  logic                          is_st, is_mem, mis;
  logic [NUM_LANES-1:0]          lane_we;
  logic [NUM_LANES-1:0][7:0]     lane_wdata;
  logic                          op_ld, op_uns;
  logic [1:0]                    op_size, op_lo;
  logic [7:0]                    rd_byte;
  logic [15:0]                   rd_half;
  logic [31:0]                   load_val;

  // A request with both is_load and is_store set is handled as a load.
  assign is_st  = is_store & ~is_load;
  assign is_mem = is_load | is_store;
  assign mis    = ((size == 2'd1) & alu_result[0]) | (size[1] & (|alu_result[1:0]));

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      mem_access_lane #(.LANE(g)) u_lane (
        .size  (size),
        .lo    (alu_result[1:0]),
        .is_st (is_st),
        .wdata (wdata),
        .we    (lane_we[g]),
        .wbyte (lane_wdata[g])
      );
    end
  endgenerate

  always_comb begin
    rd_byte = mem_rdata[{op_lo, 3'b000} +: 8];
    rd_half = op_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_size)
      2'd0:    load_val = {{24{~op_uns & rd_byte[7]}}, rd_byte};
      2'd1:    load_val = {{16{~op_uns & rd_half[15]}}, rd_half};
      default: load_val = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    completed = 1'b0;
    case (state)
      IDLE: if (enabled) state_nxt = (is_mem & ~mis) ? WAIT : DONE;
      WAIT: begin
        mem_req = 1'b1;
        if (mem_ack) state_nxt = DONE;
      end
      DONE: begin
        completed = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are frozen at capture so they stay stable for the whole WAIT.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_ld      <= 1'b0;
      op_uns     <= 1'b0;
      op_size    <= 2'd0;
      op_lo      <= 2'd0;
      mem_we     <= 4'd0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      result     <= 32'd0;
      misaligned <= 1'b0;
    end else begin
      case (state)
        IDLE: if (enabled) begin
          op_ld      <= is_load;
          op_uns     <= is_unsigned;
          op_size    <= size;
          op_lo      <= alu_result[1:0];
          misaligned <= is_mem & mis;
          if (!is_mem)  result <= alu_result;
          else if (mis) result <= 32'd0;
          if (is_mem & ~mis) begin
            mem_addr  <= alu_result[ADDR_W+1:2];
            mem_we    <= lane_we;
            mem_wdata <= lane_wdata;
          end
        end
        WAIT: if (mem_ack) begin
          mem_we <= 4'd0;
          result <= op_ld ? load_val : 32'd0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: non-memory pass-through, loads, stores, misalignment,
// reset during a pending access and ignored re-issue.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enabled = 1'b0, is_load = 1'b0, is_store = 1'b0, is_unsigned = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] alu_result = '0, wdata = '0, mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        mem_req, completed, misaligned;
  logic [3:0]  mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, result;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  mem_access #(.ADDR_W(30)) dut (
    .clk(clk), .rstn(rstn), .enabled(enabled), .is_load(is_load), .is_store(is_store),
    .size(size), .is_unsigned(is_unsigned), .alu_result(alu_result), .wdata(wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .completed(completed), .result(result),
    .misaligned(misaligned)
  );

  // One-cycle enabled pulse; returns at the negedge one cycle after the capture edge.
  task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    enabled = 1'b1; is_load = ld; is_store = st; size = sz; is_unsigned = uns;
    alu_result = a; wdata = wd;
    @(negedge clk);
    enabled = 1'b0; is_load = 1'b0; is_store = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, completed, misaligned} !== 7'd0 || result !== 32'd0 ||
        mem_addr !== 30'd0 || mem_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: req=%b we=%h cmp=%b mis=%b res=%h addr=%h wd=%h, required all zero",
               mem_req, mem_we, completed, misaligned, result, mem_addr, mem_wdata);
    end
    rstn = 1'b1;
  endtask

  task automatic test_non_mem();
    issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h12345678, 32'h0);
    checks++;
    if (completed !== 1'b1 || result !== 32'h12345678 || mem_req !== 1'b0 || misaligned !== 1'b0) begin
      errors++;
      $display("FAIL non_mem: cmp=%b res=%h req=%b mis=%b, required 1 12345678 0 0",
               completed, result, mem_req, misaligned);
    end
    @(negedge clk);
    checks++;
    if (completed !== 1'b0 || mem_req !== 1'b0 || result !== 32'h12345678) begin
      errors++;
      $display("FAIL non_mem_after: cmp=%b req=%b res=%h, required 0 0 12345678", completed, mem_req, result);
    end
  endtask

  task automatic test_load_byte(input logic uns, input logic [31:0] exp);
    issue(1'b1, 1'b0, 2'd0, uns, 32'h103, 32'h0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 30'h40 || mem_we !== 4'h0 || completed !== 1'b0) begin
        errors++;
        $display("FAIL lb_wait%0d: req=%b addr=%h we=%h cmp=%b, required 1 40 0 0", i, mem_req, mem_addr, mem_we, completed);
      end
      if (i < 2) @(negedge clk);
    end
    mem_ack = 1'b1; mem_rdata = 32'h80FFFFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if (completed !== 1'b1 || mem_req !== 1'b0 || result !== exp || misaligned !== 1'b0) begin
      errors++;
      $display("FAIL lb_uns%0d: cmp=%b req=%b res=%h mis=%b, required 1 0 %h 0", uns, completed, mem_req, result, misaligned, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_store_half();
    issue(1'b0, 1'b1, 2'd1, 1'b0, 32'h202, 32'h0000BEEF);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 4'b1100 || mem_wdata !== 32'hBEEFBEEF || mem_addr !== 30'h80) begin
        errors++;
        $display("FAIL sh_wait%0d: req=%b we=%b wd=%h addr=%h, required 1 1100 beefbeef 80", i, mem_req, mem_we, mem_wdata, mem_addr);
      end
      if (i == 0) @(negedge clk);
    end
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if (completed !== 1'b1 || result !== 32'd0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL sh_done: cmp=%b res=%h req=%b, required 1 0 0", completed, result, mem_req);
    end
    @(negedge clk);
  endtask

  task automatic test_store_byte();
    issue(1'b0, 1'b1, 2'd0, 1'b0, 32'h5, 32'h000000AB);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 4'b0010 || mem_wdata !== 32'hABABABAB || mem_addr !== 30'h1) begin
      errors++;
      $display("FAIL sb_wait: req=%b we=%b wd=%h addr=%h, required 1 0010 abababab 1", mem_req, mem_we, mem_wdata, mem_addr);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if (completed !== 1'b1 || result !== 32'd0) begin
      errors++;
      $display("FAIL sb_done: cmp=%b res=%h, required 1 0", completed, result);
    end
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h301, 32'h0);
    checks++;
    if (completed !== 1'b1 || misaligned !== 1'b1 || result !== 32'd0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL lw_misaligned: cmp=%b mis=%b res=%h req=%b, required 1 1 0 0", completed, misaligned, result, mem_req);
    end
    // half at odd address also faults
    issue(1'b1, 1'b0, 2'd1, 1'b0, 32'h1003, 32'h0);
    checks++;
    if (completed !== 1'b1 || misaligned !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL lh_misaligned: cmp=%b mis=%b req=%b, required 1 1 0", completed, misaligned, mem_req);
    end
    @(negedge clk);
  endtask

  // lh then lhu issued back to back; both-flags request must behave as a load.
  task automatic test_back_to_back();
    mem_rdata = 32'h80017FFF;
    issue(1'b1, 1'b1, 2'd1, 1'b0, 32'h2, 32'h0);
    checks++;
    if (mem_we !== 4'h0 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL both_flags_load: we=%h req=%b, required 0 1", mem_we, mem_req);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if (completed !== 1'b1 || result !== 32'hFFFF8001) begin
      errors++;
      $display("FAIL lh_hi: cmp=%b res=%h, required 1 ffff8001", completed, result);
    end
    issue(1'b1, 1'b0, 2'd1, 1'b1, 32'h0, 32'h0);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if (completed !== 1'b1 || result !== 32'h00007FFF) begin
      errors++;
      $display("FAIL lhu_lo: cmp=%b res=%h, required 1 00007fff", completed, result);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_wait: req=%b, required 1", mem_req);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || completed !== 1'b0 || mem_addr !== 30'd0 || result !== 32'd0) begin
      errors++;
      $display("FAIL rst_async: req=%b cmp=%b addr=%h res=%h, required 0 0 0 0", mem_req, completed, mem_addr, result);
    end
    @(negedge clk);
    rstn = 1'b1;
    enabled = 1'b1; is_load = 1'b1; size = 2'd2; is_unsigned = 1'b0; alu_result = 32'h0;
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    enabled = 1'b0; is_load = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || completed !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_wait: req=%b cmp=%b, required 1 0", mem_req, completed);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if (completed !== 1'b1 || result !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL post_rst_lw: cmp=%b res=%h, required 1 cafef00d", completed, result);
    end
    @(negedge clk);
  endtask

  task automatic test_reenable();
    int cnt;
    issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344);
    checks++;
    if (mem_we !== 4'hF || mem_wdata !== 32'h11223344) begin
      errors++;
      $display("FAIL sw_wait: we=%h wd=%h, required f 11223344", mem_we, mem_wdata);
    end
    enabled = 1'b1; alu_result = 32'h0000DEAD;
    @(negedge clk);
    enabled = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 30'h4 || mem_wdata !== 32'h11223344 || completed !== 1'b0) begin
      errors++;
      $display("FAIL reenable_wait: req=%b addr=%h wd=%h cmp=%b, required 1 4 11223344 0", mem_req, mem_addr, mem_wdata, completed);
    end
    mem_ack = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (completed === 1'b1) cnt++;
      if (i == 0) begin
        mem_ack = 1'b0;
        checks++;
        if (completed !== 1'b1 || result !== 32'd0) begin
          errors++;
          $display("FAIL sw_done: cmp=%b res=%h, required 1 0", completed, result);
        end
      end
    end
    checks++;
    if (cnt !== 1) begin
      errors++;
      $display("FAIL reenable_pulses: count=%0d, required 1", cnt);
    end
  endtask

  initial begin
    test_reset();
    test_non_mem();
    test_load_byte(1'b0, 32'hFFFFFF80);
    test_load_byte(1'b1, 32'h00000080);
    test_store_half();
    test_store_byte();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_wait();
    test_reenable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
